// File: rtl/tlb_ptw.sv
// Two-level Sv32-style page table walker between the TLB miss port
// and a single-read memory port; returns one leaf PTE or zero on fault.
module tlb_ptw #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ptw_req_valid_i,
  output logic               ptw_req_ready_o,
  input  logic [31:0]        ptw_vaddr_i,
  output logic               ptw_resp_valid_o,
  input  logic               ptw_resp_ready_i,
  output logic [31:0]        ptw_pte_o,
  output logic               ptw_fault_o,
  input  logic [19:0]        satp_ppn_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_resp_valid_i,
  input  logic [31:0]        mem_resp_data_i,
  output logic [COUNT_W-1:0] walk_count_o
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic [19:0]        vpn_q;
  logic [19:0]        root_q;
  logic [19:0]        l1_ppn_q;
  logic [31:0]        pte_q;
  logic               fault_q;
  logic [COUNT_W-1:0] count_q;

  logic req_fire;
  logic d_v, d_leaf, d_ptr, sp_misaligned;

  assign req_fire      = ptw_req_valid_i && ptw_req_ready_o;
  assign d_v           = mem_resp_data_i[2];
  assign d_leaf        = d_v && (mem_resp_data_i[1] | mem_resp_data_i[0]);
  assign d_ptr         = d_v && !(mem_resp_data_i[1] | mem_resp_data_i[0]);
  assign sp_misaligned = |mem_resp_data_i[21:12];

  assign ptw_pte_o    = pte_q;
  assign ptw_fault_o  = fault_q;
  assign walk_count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire) state_d = L1_REQ;
      L1_REQ:  if (mem_req_ready_i) state_d = L1_WAIT;
      L1_WAIT: if (mem_resp_valid_i)
                 state_d = d_ptr ? L0_REQ : RESP;
      L0_REQ:  if (mem_req_ready_i) state_d = L0_WAIT;
      L0_WAIT: if (mem_resp_valid_i) state_d = RESP;
      RESP:    if (ptw_resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated while rst is high so nothing leaks before the
  // synchronous reset takes effect on the state register.
  always_comb begin
    ptw_req_ready_o  = 1'b0;
    ptw_resp_valid_o = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_addr_o       = 32'd0;
    if (!rst) begin
      unique case (state_q)
        IDLE: ptw_req_ready_o = 1'b1;
        L1_REQ: begin
          mem_req_valid_o = 1'b1;
          mem_addr_o      = {root_q, vpn_q[19:10], 2'b00};
        end
        L0_REQ: begin
          mem_req_valid_o = 1'b1;
          mem_addr_o      = {l1_ppn_q, vpn_q[9:0], 2'b00};
        end
        RESP:    ptw_resp_valid_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpn_q    <= '0;
      root_q   <= '0;
      l1_ppn_q <= '0;
      pte_q    <= '0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      if (req_fire) begin
        vpn_q   <= ptw_vaddr_i[31:12];
        root_q  <= satp_ppn_i;
        count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
      if (state_q == L1_WAIT && mem_resp_valid_i) begin
        if (d_ptr) begin
          l1_ppn_q <= mem_resp_data_i[31:12];
        end else if (d_leaf && !sp_misaligned) begin
          pte_q   <= {mem_resp_data_i[31:22], vpn_q[9:0],
                      mem_resp_data_i[11:0]};
          fault_q <= 1'b0;
        end else begin
          pte_q   <= 32'd0;
          fault_q <= 1'b1;
        end
      end
      if (state_q == L0_WAIT && mem_resp_valid_i) begin
        pte_q   <= d_leaf ? mem_resp_data_i : 32'd0;
        fault_q <= !d_leaf;
      end
    end
  end

endmodule

// File: tb/tb_tlb_ptw.sv
// Vector table plus scoreboard bench for the page table walker,
// with hand sequences for backpressure and reset mid-walk.
module tb_tlb_ptw;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ptw_req_valid, ptw_req_ready;
  logic [31:0]   ptw_vaddr;
  logic          ptw_resp_valid, ptw_resp_ready;
  logic [31:0]   ptw_pte;
  logic          ptw_fault;
  logic [19:0]   satp_ppn;
  logic          mem_req_valid, mem_req_ready;
  logic [31:0]   mem_addr;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_data;
  logic [CW-1:0] walk_count;

  tlb_ptw #(.COUNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .ptw_req_valid_i  (ptw_req_valid),
    .ptw_req_ready_o  (ptw_req_ready),
    .ptw_vaddr_i      (ptw_vaddr),
    .ptw_resp_valid_o (ptw_resp_valid),
    .ptw_resp_ready_i (ptw_resp_ready),
    .ptw_pte_o        (ptw_pte),
    .ptw_fault_o      (ptw_fault),
    .satp_ppn_i       (satp_ppn),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_addr_o       (mem_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data),
    .walk_count_o     (walk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] satp;
    logic [31:0] vaddr;
    logic [31:0] l1_addr;
    logic [31:0] l1_data;
    bit          two;
    logic [31:0] l0_addr;
    logic [31:0] l0_data;
    logic [31:0] pte;
    logic        fault;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] pte;
    logic        fault;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   exp_count = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] va, input logic [19:0] sp,
                       input logic [31:0] epte, input logic ef);
    exp_t e;
    ptw_vaddr     = va;
    satp_ppn      = sp;
    ptw_req_valid = 1'b1;
    for (int i = 0; i < 20 && !ptw_req_ready; i++) tick();
    chk("req_ready", 32'(ptw_req_ready), 32'd1);
    tick();
    accept_cyc    = cyc - 1;
    ptw_req_valid = 1'b0;
    ptw_vaddr     = ~va;
    satp_ppn      = ~sp;
    e.pte         = epte;
    e.fault       = ef;
    exp_q.push_back(e);
    exp_count++;
    chk("walk_count", 32'(walk_count), 32'(exp_count % (1 << CW)));
  endtask

  task automatic mem_serve(input logic [31:0] ea, input logic [31:0] d,
                           input int dly);
    for (int i = 0; i < 20 && !mem_req_valid; i++) tick();
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mem_addr", mem_addr, ea);
    for (int i = 0; i < dly; i++) begin
      mem_req_ready = 1'b0;
      tick();
      chk("mem_addr_hold", mem_addr, ea);
      chk("mem_valid_hold", 32'(mem_req_valid), 32'd1);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_resp(input int hold, input int lat);
    exp_t e;
    logic [31:0] p0;
    for (int i = 0; i < 20 && !ptw_resp_valid; i++) tick();
    chk("resp_valid", 32'(ptw_resp_valid), 32'd1);
    if (lat != 0) chk("latency", 32'(cyc - accept_cyc), 32'(lat));
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got response expected none");
    end else begin
      e = exp_q.pop_front();
      chk("pte", ptw_pte, e.pte);
      chk("fault", 32'(ptw_fault), 32'(e.fault));
    end
    p0 = ptw_pte;
    for (int i = 0; i < hold; i++) begin
      ptw_req_valid = 1'b1;
      tick();
      chk("pte_hold", ptw_pte, p0);
      chk("busy_ready", 32'(ptw_req_ready), 32'd0);
      chk("resp_hold", 32'(ptw_resp_valid), 32'd1);
    end
    ptw_req_valid  = 1'b0;
    ptw_resp_ready = 1'b1;
    tick();
    ptw_resp_ready = 1'b0;
    chk("count_stable", 32'(walk_count), 32'(exp_count % (1 << CW)));
  endtask

  task automatic run_vec(input vec_t v, input int dly, input int hold);
    issue(v.vaddr, v.satp, v.pte, v.fault);
    mem_serve(v.l1_addr, v.l1_data, dly);
    if (v.two) mem_serve(v.l0_addr, v.l0_data, dly);
    wait_resp(hold, (dly == 0) ? v.lat : 0);
  endtask

  initial begin
    vecs[0] = '{20'h00010, 32'h12345678, 32'h00010120, 32'h00020004, 1'b1,
                32'h00020D14, 32'hABCDE007, 32'hABCDE007, 1'b0, 5};
    vecs[1] = '{20'h00010, 32'h12345678, 32'h00010120, 32'h80000005, 1'b0,
                32'h0, 32'h0, 32'h80345005, 1'b0, 3};
    vecs[2] = '{20'h00010, 32'h12345678, 32'h00010120, 32'h00020000, 1'b0,
                32'h0, 32'h0, 32'h0, 1'b1, 3};
    vecs[3] = '{20'h00010, 32'h12345678, 32'h00010120, 32'h80001005, 1'b0,
                32'h0, 32'h0, 32'h0, 1'b1, 3};
    vecs[4] = '{20'h00010, 32'h12345678, 32'h00010120, 32'h00020004, 1'b1,
                32'h00020D14, 32'h00030004, 32'h0, 1'b1, 5};
    vecs[5] = '{20'hFFFFF, 32'hFFC00000, 32'hFFFFFFFC, 32'h00001004, 1'b1,
                32'h00001000, 32'h12345006, 32'h12345006, 1'b0, 5};
    vecs[6] = '{20'h00ABC, 32'h00401000, 32'h00ABC004, 32'h00055004, 1'b1,
                32'h00055004, 32'h00000000, 32'h0, 1'b1, 5};

    rst = 1'b1;
    ptw_req_valid  = 1'b0;
    ptw_vaddr      = 32'h0;
    ptw_resp_ready = 1'b0;
    satp_ppn       = 20'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    tick();
    tick();
    chk("rst_req_ready", 32'(ptw_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(ptw_resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_pte", ptw_pte, 32'd0);
    chk("rst_fault", 32'(ptw_fault), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_count", 32'(walk_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(ptw_req_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0, 0);

    run_vec(vecs[0], 3, 4);

    // Reset while waiting on the level-0 read, then a stray response
    issue(vecs[0].vaddr, vecs[0].satp, vecs[0].pte, vecs[0].fault);
    mem_serve(vecs[0].l1_addr, vecs[0].l1_data, 0);
    for (int i = 0; i < 20 && !mem_req_valid; i++) tick();
    chk("l0_req", mem_addr, vecs[0].l0_addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    void'(exp_q.pop_front());
    rst = 1'b1;
    chk("mid_rst_ready", 32'(ptw_req_ready), 32'd0);
    tick();
    chk("mid_rst_pte", ptw_pte, 32'd0);
    chk("mid_rst_fault", 32'(ptw_fault), 32'd0);
    chk("mid_rst_count", 32'(walk_count), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    rst = 1'b0;
    exp_count = 0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hABCDE007;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_ready", 32'(ptw_req_ready), 32'd1);
    chk("post_rst_resp", 32'(ptw_resp_valid), 32'd0);
    chk("post_rst_mem", 32'(mem_req_valid), 32'd0);
    chk("post_rst_pte", ptw_pte, 32'd0);
    chk("post_rst_count", 32'(walk_count), 32'd0);

    run_vec(vecs[1], 0, 0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_ptw.md
Name: tlb_ptw

Overview:
Page table walker that services TLB miss requests. It sits between the TLB's PTW request/response port and a single-read memory port. For each request it performs a two-level (Sv32-style) walk from the root page-table base and returns one 4 KB-granular leaf PTE, or an all-zero PTE on fault. A zero PTE carries no permission bits, so the TLB reports an access fault.

Parameters:
COUNT_W, 16, width of the walk-count statistics counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ptw_req_valid_i  input  1  TLB walk request valid
ptw_req_ready_o  output  1  walker can accept a request
ptw_vaddr_i  input  32  virtual address to translate
ptw_resp_valid_o  output  1  walk result valid
ptw_resp_ready_i  input  1  TLB accepts the result
ptw_pte_o  output  32  returned leaf PTE (0 on fault)
ptw_fault_o  output  1  walk faulted (sideband, qualified by resp_valid)
satp_ppn_i  input  20  root page-table PPN; sampled at request accept
mem_req_valid_o  output  1  memory read request valid
mem_req_ready_i  input  1  memory accepts the request
mem_addr_o  output  32  word-aligned PTE address
mem_resp_valid_i  input  1  read data valid (one beat per request, in order)
mem_resp_data_i  input  32  PTE read data
walk_count_o  output  COUNT_W  number of accepted walk requests, wraps modulo 2^COUNT_W

Behaviour:
- PTE format:
  - [31:12] PPN; [2] V; [1] W; [0] R; [11:3] reserved, passed through.
  - Leaf: V=1 and (R|W)=1.
  - Pointer: V=1 and R=W=0.
  - Invalid: V=0.
- Request fields: VPN1=vaddr[31:22], VPN0=vaddr[21:12].
- FSM states: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- IDLE:
  - ptw_req_ready_o=1.
  - On valid&ready, latch vaddr and satp_ppn_i, increment walk_count_o, go to L1_REQ.
- L1_REQ:
  - mem_req_valid_o=1, mem_addr_o={satp_ppn, VPN1, 2'b00}.
  - Valid and address held stable until mem_req_ready_i, then go to L1_WAIT.
- L1_WAIT (on mem_resp_valid_i):
  - Invalid -> fault.
  - Pointer -> latch PPN, go to L0_REQ.
  - Leaf (superpage): if data[21:12]!=0 (misaligned) -> fault. Otherwise result = {data[31:22], VPN0, data[11:0]}, fault=0, go to RESP.
- L0_REQ:
  - mem_addr_o={l1_ppn, VPN0, 2'b00}, same handshake as L1_REQ; then go to L0_WAIT.
- L0_WAIT (on mem_resp_valid_i):
  - Leaf -> result = data unchanged, fault=0.
  - Invalid or pointer (depth exceeded) -> fault.
  - Go to RESP.
- Fault result: ptw_pte_o=32'd0, ptw_fault_o=1.
- RESP:
  - ptw_resp_valid_o=1; ptw_pte_o and ptw_fault_o are registered and held stable.
  - On ptw_resp_ready_i go to IDLE. No new request is accepted in the same cycle.
- ptw_req_ready_o is 1 only in IDLE. Only one walk is outstanding; ptw_req_valid_i outside IDLE is ignored (request stays pending upstream).
- mem_resp_valid_i outside L1_WAIT/L0_WAIT is ignored. No memory response is ever dropped inside a WAIT state.
- Minimum latency, with memory ready immediately and data one cycle after accept:
  - Accept at T, memory request visible at T+1.
  - 4 KB leaf: ptw_resp_valid_o at T+5.
  - Superpage leaf: ptw_resp_valid_o at T+3.
- Reset values:
  - state=IDLE.
  - All valid outputs 0; ptw_req_ready_o forced to 0 while rst=1.
  - ptw_pte_o=0, ptw_fault_o=0, mem_addr_o=0, walk_count_o=0.
- Reset mid-walk: abandons the walk and returns to IDLE; any later memory response is ignored.
- walk_count_o wraps from all-ones to 0.

Test Plan:
- 4 KB walk: satp_ppn=0x00010, vaddr=0x12345678 -> mem_addr 0x00010120; return 0x00020004 -> mem_addr 0x00020D14; return 0xABCDE007 -> pte_o=0xABCDE007, fault_o=0, walk_count_o=1.
- Superpage: same vaddr, L1 data 0x80000005 -> only one memory read; pte_o=0x80345005, fault_o=0, resp_valid at T+3.
- Faults, each giving pte_o=0 and fault_o=1:
  - L1 data 0x00020000 (V=0).
  - L1 data 0x80001005 (misaligned superpage).
  - L0 data 0x00030004 (pointer at level 0).
- Backpressure:
  - mem_req_ready_i low 3 cycles -> mem_addr_o stable, no state advance.
  - ptw_resp_ready_i low 4 cycles -> pte_o/fault_o held, second ptw_req_valid_i not accepted (req_ready_o=0).
- Reset in L0_WAIT, then a stray mem_resp_valid_i -> all outputs at reset values, stays IDLE, walk_count_o=0.
- Counter wrap: with COUNT_W=2, five walks -> walk_count_o reads 1,2,3,0,1.
